full_adder: RTL and testbench
=============================

FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 1, meaning operand width in bits (legal range 1..64).
REQ-002 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, meaning reset; reset is synchronous and active-high.
REQ-004 SHALL have port x, input, WIDTH bits, meaning addend A, unsigned.
REQ-005 SHALL have port y, input, WIDTH bits, meaning addend B, unsigned.
REQ-006 SHALL have port Cin, input, 1 bit, meaning carry-in, weight 2^0.
REQ-007 SHALL have port in_vld, input, 1 bit, meaning x/y/Cin are valid this cycle.
REQ-008 SHALL have port Sum, output, WIDTH bits, meaning registered sum bits (x+y+Cin) mod 2^WIDTH.
REQ-009 SHALL have port Cout, output, 1 bit, meaning registered carry-out, bit WIDTH of x+y+Cin.
REQ-010 SHALL have port out_vld, output, 1 bit, meaning Sum/Cout hold a result produced from a valid input.

Function
REQ-011 SHALL compute {Cout,Sum} = x + y + Cin as a (WIDTH+1)-bit unsigned result with no truncation of the carry.
REQ-012 SHALL implement the sum as a ripple of 1-bit full-adder cells: s_i = x_i^y_i^c_i, c_(i+1) = x_i&y_i | c_i&(x_i^y_i), c_0 = Cin.
REQ-013 SHALL register Sum, Cout and out_vld; latency from in_vld sampled high to out_vld high is 1 clock (macro off).
REQ-014 SHALL load Sum/Cout only on cycles where in_vld=1; with in_vld=0 Sum/Cout hold their previous values.
REQ-015 SHALL drive out_vld = in_vld delayed by the pipeline latency, one result per valid input, no back-pressure.
REQ-016 SHALL accept back-to-back valid inputs every cycle, full throughput.
REQ-017 SHALL treat boundary cases exactly: all-ones + all-ones + 1 gives Sum all-ones, Cout=1; zero + zero + 0 gives Sum=0, Cout=0.
REQ-018 SHALL have no combinational path from any input to any output.

Reset
REQ-019 SHALL, when rst=1 at a rising clk edge, set Sum=0, Cout=0, out_vld=0, and clear any internal pipeline stage and its valid bit.
REQ-020 SHALL give rst priority over in_vld; an input presented in a reset cycle is discarded and produces no out_vld.
REQ-021 SHALL, on reset asserted mid-operation, drop any in-flight result; the first out_vld after reset deasserts comes from the first valid input sampled with rst=0.

Configuration
REQ-022 SHALL provide macro FULL_ADDER_INREG_EN; when defined, x, y, Cin and in_vld are captured in an input register stage before the adder, total latency 2 clocks.
REQ-023 SHALL, without FULL_ADDER_INREG_EN, have no input register stage and latency 1 clock; function and reset behaviour otherwise identical.
REQ-024 SHALL reset the input stage (when present) to all zeros, valid bit 0.

Verification
REQ-025 SHALL cover, WIDTH=1, the exhaustive 8-row table: each of the 8 x/y/Cin combinations with in_vld=1 -> after latency Sum/Cout = 0/0, 1/0, 1/0, 0/1, 1/0, 0/1, 0/1, 1/1 in order 000..111.
REQ-026 SHALL cover, WIDTH=8, x=0xFF, y=0xFF, Cin=1 -> Sum=0xFF, Cout=1; and x=0x80, y=0x80, Cin=0 -> Sum=0x00, Cout=1.
REQ-027 SHALL cover hold behaviour: valid x=1,y=0,Cin=0 (WIDTH=1) then in_vld=0 with x=1,y=1,Cin=1 -> Sum=1, Cout=0 held, out_vld=0 after one cycle.
REQ-028 SHALL cover reset: rst=1 for one cycle with in_vld=1, x=1,y=1,Cin=1 -> Sum=0, Cout=0, out_vld=0 in the following cycle.
REQ-029 SHALL cover throughput: 16 consecutive random valid inputs, WIDTH=8 -> 16 consecutive out_vld pulses, each matching x+y+Cin, with latency 1 (macro off) or 2 (macro on).

Source files
------------

// File: rtl/full_adder.sv
// Purpose: registered WIDTH-bit ripple-carry adder, {Cout,Sum} = x + y + Cin.
// Latency: 1 clock; 2 clocks with FULL_ADDER_INREG_EN defined (adds an input register stage).
// Backpressure: none; accepts one valid input every cycle, out_vld is in_vld delayed.
module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             Cin,
    input  logic             in_vld,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             out_vld
);

    logic [WIDTH-1:0] add_x;
    logic [WIDTH-1:0] add_y;
    logic             add_cin;
    logic             add_vld;

`ifdef FULL_ADDER_INREG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            add_x   <= '0;
            add_y   <= '0;
            add_cin <= 1'b0;
            add_vld <= 1'b0;
        end else begin
            add_x   <= x;
            add_y   <= y;
            add_cin <= Cin;
            add_vld <= in_vld;
        end
    end
`else
    always_comb begin
        add_x   = x;
        add_y   = y;
        add_cin = Cin;
        add_vld = in_vld;
    end
`endif

    logic [WIDTH-1:0] sum_c;
    logic             cout_c;
    logic             carry;

    // Chain of 1-bit full-adder cells; carry ripples LSB to MSB.
    always_comb begin
        sum_c = '0;
        carry = add_cin;
        for (int i = 0; i < WIDTH; i++) begin
            sum_c[i] = add_x[i] ^ add_y[i] ^ carry;
            carry    = (add_x[i] & add_y[i]) | (carry & (add_x[i] ^ add_y[i]));
        end
        cout_c = carry;
    end

    // Result registers hold their value across idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            Sum     <= '0;
            Cout    <= 1'b0;
            out_vld <= 1'b0;
        end else begin
            out_vld <= add_vld;
            if (add_vld) begin
                Sum  <= sum_c;
                Cout <= cout_c;
            end
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH=1 and WIDTH=8 against an arithmetic model.
module tb_full_adder;

`ifdef FULL_ADDER_INREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       x1, y1, c1, v1;
    logic       sum1, cout1, ovld1;
    logic [7:0] x8, y8;
    logic       c8, v8;
    logic [7:0] sum8;
    logic       cout8, ovld8;

    full_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .x(x1), .y(y1), .Cin(c1), .in_vld(v1),
        .Sum(sum1), .Cout(cout1), .out_vld(ovld1)
    );

    full_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .x(x8), .y(y8), .Cin(c8), .in_vld(v8),
        .Sum(sum8), .Cout(cout8), .out_vld(ovld8)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: each accepted input becomes the integer x+y+Cin, visible LAT edges later.
    logic        qv1 [2];
    logic [63:0] qr1 [2];
    logic        qv8 [2];
    logic [63:0] qr8 [2];
    logic        ev1, ev8;
    logic [63:0] held1, held8;
    logic        chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            qv1[0] <= 1'b0; qv1[1] <= 1'b0; qr1[0] <= '0; qr1[1] <= '0;
            qv8[0] <= 1'b0; qv8[1] <= 1'b0; qr8[0] <= '0; qr8[1] <= '0;
            ev1 <= 1'b0; ev8 <= 1'b0; held1 <= '0; held8 <= '0;
        end else begin
            qv1[0] <= v1; qr1[0] <= 64'(x1) + 64'(y1) + 64'(c1);
            qv8[0] <= v8; qr8[0] <= 64'(x8) + 64'(y8) + 64'(c8);
            qv1[1] <= qv1[0]; qr1[1] <= qr1[0];
            qv8[1] <= qv8[0]; qr8[1] <= qr8[0];
            if (LAT == 1) begin
                ev1 <= v1;
                ev8 <= v8;
                if (v1) held1 <= 64'(x1) + 64'(y1) + 64'(c1);
                if (v8) held8 <= 64'(x8) + 64'(y8) + 64'(c8);
            end else begin
                ev1 <= qv1[0];
                ev8 <= qv8[0];
                if (qv1[0]) held1 <= qr1[0];
                if (qv8[0]) held8 <= qr8[0];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_vld1", 64'(ovld1), 64'(ev1));
            check("model_res1", 64'({cout1, sum1}), held1);
            check("model_vld8", 64'(ovld8), 64'(ev8));
            check("model_res8", 64'({cout8, sum8}), held8);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one valid input to dut8 and wait until its result is registered.
    task automatic run8(input logic [7:0] xa, input logic [7:0] ya, input logic ca,
                        input logic [8:0] exp, input string tag);
        x8 = xa; y8 = ya; c8 = ca; v8 = 1'b1;
        repeat (LAT) begin
            cyc();
            v8 = 1'b0;
        end
        check(tag, 64'({cout8, sum8}), 64'(exp));
        check({tag, "_vld"}, 64'(ovld8), 64'd1);
    endtask

    logic [1:0] tt_exp [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    initial begin
        int pulses;
        int first_k;
        rst = 1'b1;
        x1 = 1'b0; y1 = 1'b0; c1 = 1'b0; v1 = 1'b0;
        x8 = '0;   y8 = '0;   c8 = 1'b0; v8 = 1'b0;
        cyc();
        cyc();
        check("reset_res1", 64'({cout1, sum1, ovld1}), 64'd0);
        check("reset_res8", 64'({cout8, sum8, ovld8}), 64'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Exhaustive 1-bit truth table, order x,y,Cin = 000..111.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] idx;
            idx = 3'(i);
            x1 = idx[2]; y1 = idx[1]; c1 = idx[0]; v1 = 1'b1;
            repeat (LAT) begin
                cyc();
                v1 = 1'b0;
            end
            check($sformatf("tt%0d", i), 64'({cout1, sum1}), 64'(tt_exp[i]));
            check($sformatf("tt%0d_vld", i), 64'(ovld1), 64'd1);
        end

        // Hold: idle inputs must not disturb the registered result.
        x1 = 1'b1; y1 = 1'b0; c1 = 1'b0; v1 = 1'b1;
        repeat (LAT) begin
            cyc();
            v1 = 1'b0; x1 = 1'b1; y1 = 1'b1; c1 = 1'b1;
        end
        cyc();
        check("hold_res", 64'({cout1, sum1}), 64'b01);
        check("hold_vld", 64'(ovld1), 64'd0);

        // 8-bit boundaries.
        run8(8'hFF, 8'hFF, 1'b1, 9'h1FF, "ff_ff_1");
        run8(8'h80, 8'h80, 1'b0, 9'h100, "80_80_0");
        run8(8'h00, 8'h00, 1'b0, 9'h000, "00_00_0");

        // Reset wins over a valid input.
        cyc();
        rst = 1'b1; v1 = 1'b1; x1 = 1'b1; y1 = 1'b1; c1 = 1'b1;
        cyc();
        rst = 1'b0; v1 = 1'b0;
        check("rst_res", 64'({cout1, sum1}), 64'd0);
        check("rst_vld", 64'(ovld1), 64'd0);
        cyc();
        check("rst_vld_next", 64'(ovld1), 64'd0);

        // Throughput: 16 back-to-back valid inputs.
        pulses = 0;
        first_k = -1;
        x8 = 8'($urandom); y8 = 8'($urandom); c8 = 1'($urandom); v8 = 1'b1;
        for (int k = 1; k <= 16 + LAT; k++) begin
            cyc();
            if (ovld8) begin
                pulses++;
                if (first_k < 0) first_k = k;
            end
            if (k < 16) begin
                x8 = 8'($urandom); y8 = 8'($urandom); c8 = 1'($urandom);
            end else begin
                v8 = 1'b0;
            end
        end
        check("burst_pulses", 64'(pulses), 64'd16);
        check("burst_latency", 64'(first_k), 64'(LAT));

        // Random traffic with sparse valids and occasional mid-stream resets.
        for (int n = 0; n < 400; n++) begin
            cyc();
            rst = ($urandom_range(0, 39) == 0);
            x1 = 1'($urandom); y1 = 1'($urandom); c1 = 1'($urandom);
            v1 = ($urandom_range(0, 3) != 0);
            x8 = 8'($urandom); y8 = 8'($urandom); c8 = 1'($urandom);
            v8 = ($urandom_range(0, 3) != 0);
        end
        cyc();
        rst = 1'b0; v1 = 1'b0; v8 = 1'b0;
        repeat (LAT + 1) cyc();
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
